// File: rtl/mips_perf_cnt_bank.sv
// rtl/mips_perf_cnt_bank.sv - parametrised event-selectable performance counter bank with host register port
module mips_perf_cnt_bank #(
    parameter int NUM_CNT   = 16,
    parameter int CNT_W     = 32,
    parameter int NUM_EVT   = 32,
    parameter int EVT_SEL_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_EVT-1:0]       evt,
    input  logic                     reg_wen,
    input  logic                     reg_ren,
    input  logic [7:0]               reg_addr,
    input  logic [31:0]              reg_wdata,
    output logic [31:0]              reg_rdata,
    output logic                     reg_rvalid,
    output logic                     irq,
    output logic [NUM_CNT*CNT_W-1:0] cnt_out
);
    localparam int         EVT_PAD  = 1 << EVT_SEL_W;
    localparam logic [6:0] NUM_CNT7 = 7'(NUM_CNT);

    logic [CNT_W-1:0]     cnt_q [NUM_CNT];
    logic [EVT_SEL_W-1:0] sel_q [NUM_CNT];
    logic [NUM_CNT-1:0]   en_q, ovf_sts, ovf_ie;
    logic                 global_en, freeze;

    logic [NUM_CNT-1:0]   cnt_wr, cfg_wr, cnt_inc, ovf_set, ovf_w1c;
    logic [EVT_PAD-1:0]   evt_ext;
    logic [7:0]           bank_off;
    logic [6:0]           bank_idx;
    logic                 in_bank, clear_all;
    logic [31:0]          rd_val;
    logic                 unused_wdata;

    assign bank_off     = reg_addr - 8'h10;
    assign bank_idx     = bank_off[7:1];
    assign in_bank      = (reg_addr >= 8'h10) && (bank_idx < NUM_CNT7);
    assign clear_all    = reg_wen && (reg_addr == 8'h00) && reg_wdata[1];
    assign ovf_w1c      = (reg_wen && reg_addr == 8'h01) ? reg_wdata[NUM_CNT-1:0] : '0;
    assign irq          = |(ovf_sts & ovf_ie);
    assign unused_wdata = ^reg_wdata;

    // Out-of-range selects land on zero-padded bits, so they never hit.
    always_comb begin
        evt_ext              = '0;
        evt_ext[NUM_EVT-1:0] = evt;
    end

    always_comb begin
        cnt_wr  = '0;
        cfg_wr  = '0;
        cnt_inc = '0;
        ovf_set = '0;
        cnt_out = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_wr[i]  = reg_wen && in_bank && !bank_off[0] && (bank_idx == 7'(i));
            cfg_wr[i]  = reg_wen && in_bank &&  bank_off[0] && (bank_idx == 7'(i));
            cnt_inc[i] = global_en && !freeze && en_q[i] && evt_ext[sel_q[i]];
            // Overflow only flags when the increment is the winning action.
            ovf_set[i] = cnt_inc[i] && !clear_all && !cnt_wr[i] && (&cnt_q[i]);
            cnt_out[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            en_q      <= '0;
            ovf_sts   <= '0;
            ovf_ie    <= '0;
            global_en <= 1'b0;
            freeze    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (clear_all)
                    cnt_q[i] <= '0;
                else if (cnt_wr[i])
                    cnt_q[i] <= reg_wdata[CNT_W-1:0];
                else if (cnt_inc[i])
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                if (cfg_wr[i]) begin
                    sel_q[i] <= reg_wdata[EVT_SEL_W-1:0];
                    en_q[i]  <= reg_wdata[31];
                end
            end
            ovf_sts <= (ovf_sts & ~ovf_w1c) | ovf_set;
            if (reg_wen && reg_addr == 8'h02)
                ovf_ie <= reg_wdata[NUM_CNT-1:0];
            if (reg_wen && reg_addr == 8'h00) begin
                global_en <= reg_wdata[0];
                freeze    <= reg_wdata[2];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_addr)
            8'h00:   rd_val = {29'd0, freeze, 1'b0, global_en};
            8'h01:   rd_val[NUM_CNT-1:0] = ovf_sts;
            8'h02:   rd_val[NUM_CNT-1:0] = ovf_ie;
            default: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (in_bank && bank_idx == 7'(i)) begin
                        if (bank_off[0]) begin
                            rd_val[31]            = en_q[i];
                            rd_val[EVT_SEL_W-1:0] = sel_q[i];
                        end else begin
                            rd_val[CNT_W-1:0] = cnt_q[i];
                        end
                    end
                end
            end
        endcase
    end

    // Read samples pre-write state, so a same-cycle write is not visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_ren;
            if (reg_ren)
                reg_rdata <= rd_val;
        end
    end
endmodule

// File: tb/tb_mips_perf_cnt_bank.sv
// tb/tb_mips_perf_cnt_bank.sv - randomized bench for mips_perf_cnt_bank against a behavioural model
module tb_mips_perf_cnt_bank;
    localparam int NEVT = 20;

    logic            clk, rst;
    logic [NEVT-1:0] evt;
    logic            reg_wen, reg_ren;
    logic [7:0]      reg_addr;
    logic [31:0]     reg_wdata;
    logic [31:0]     rdata_a, rdata_b;
    logic            rvalid_a, rvalid_b, irq_a, irq_b;
    logic [511:0]    cnt_out_a;
    logic [31:0]     cnt_out_b;

    mips_perf_cnt_bank #(.NUM_CNT(16), .CNT_W(32), .NUM_EVT(NEVT), .EVT_SEL_W(5)) dut_a (
        .clk(clk), .rst(rst), .evt(evt), .reg_wen(reg_wen), .reg_ren(reg_ren),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_a),
        .reg_rvalid(rvalid_a), .irq(irq_a), .cnt_out(cnt_out_a));

    mips_perf_cnt_bank #(.NUM_CNT(4), .CNT_W(8), .NUM_EVT(NEVT), .EVT_SEL_W(5)) dut_b (
        .clk(clk), .rst(rst), .evt(evt), .reg_wen(reg_wen), .reg_ren(reg_ren),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_b),
        .reg_rvalid(rvalid_b), .irq(irq_b), .cnt_out(cnt_out_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              ncnt [2] = '{16, 4};
    int              cw   [2] = '{32, 8};
    longint unsigned mcnt [2][16];
    int unsigned     msel [2][16];
    bit              men  [2][16];
    bit              mgen [2];
    bit              mfrz [2];
    longint unsigned msts [2];
    longint unsigned mie  [2];
    logic [31:0]     mrdata [2];
    bit              mrvalid [2];
    int              total = 0;
    int              bad = 0;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic longint unsigned wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [31:0] mread(input int n, input logic [7:0] a);
        int i;
        if (a == 8'h00) return {29'd0, mfrz[n], 1'b0, mgen[n]};
        if (a == 8'h01) return 32'(msts[n]);
        if (a == 8'h02) return 32'(mie[n]);
        if (a >= 8'h10 && int'(a) < 16 + 2 * ncnt[n]) begin
            i = (int'(a) - 16) / 2;
            if (a[0]) return {men[n][i], 26'd0, 5'(msel[n][i])};
            return 32'(mcnt[n][i]);
        end
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 16; i++) begin
                mcnt[n][i] = 0;
                msel[n][i] = 0;
                men[n][i]  = 0;
            end
            mgen[n] = 0; mfrz[n] = 0; msts[n] = 0; mie[n] = 0;
            mrdata[n] = 0; mrvalid[n] = 0;
        end
    endtask

    task automatic model_step(input bit we, input bit re, input logic [7:0] a,
                              input logic [31:0] wd, input logic [NEVT-1:0] ev);
        logic [31:0]     rv;
        bit              clr, hit;
        longint unsigned set;
        for (int n = 0; n < 2; n++) begin
            rv  = mread(n, a);
            clr = we && a == 8'h00 && wd[1];
            set = 0;
            for (int i = 0; i < ncnt[n]; i++) begin
                hit = 0;
                if (mgen[n] && !mfrz[n] && men[n][i] && msel[n][i] < NEVT)
                    hit = ev[msel[n][i]];
                if (clr)
                    mcnt[n][i] = 0;
                else if (we && int'(a) == 16 + 2 * i)
                    mcnt[n][i] = {32'd0, wd} & wmask(cw[n]);
                else if (hit) begin
                    mcnt[n][i] = (mcnt[n][i] + 1) % (64'd1 << cw[n]);
                    if (mcnt[n][i] == 0) set = set | (64'd1 << i);
                end
            end
            if (we && a == 8'h01) msts[n] = msts[n] & ~{32'd0, wd};
            msts[n] = (msts[n] | set) & wmask(ncnt[n]);
            if (we && a == 8'h02) mie[n] = {32'd0, wd} & wmask(ncnt[n]);
            for (int i = 0; i < ncnt[n]; i++) begin
                if (we && int'(a) == 17 + 2 * i) begin
                    msel[n][i] = wd[4:0];
                    men[n][i]  = wd[31];
                end
            end
            if (we && a == 8'h00) begin
                mgen[n] = wd[0];
                mfrz[n] = wd[2];
            end
            if (re) mrdata[n] = rv;
            mrvalid[n] = re;
        end
    endtask

    task automatic check_all();
        logic [511:0] e [2];
        for (int n = 0; n < 2; n++) begin
            e[n] = '0;
            for (int i = 0; i < ncnt[n]; i++)
                e[n] = e[n] | (512'(mcnt[n][i]) << (i * cw[n]));
        end
        check("cnt_out_a", cnt_out_a, e[0]);
        check("cnt_out_b", 512'(cnt_out_b), e[1]);
        check("irq_a", 512'(irq_a), 512'((msts[0] & mie[0]) != 0));
        check("irq_b", 512'(irq_b), 512'((msts[1] & mie[1]) != 0));
        check("rvalid_a", 512'(rvalid_a), 512'(mrvalid[0]));
        check("rvalid_b", 512'(rvalid_b), 512'(mrvalid[1]));
        check("rdata_a", 512'(rdata_a), 512'(mrdata[0]));
        check("rdata_b", 512'(rdata_b), 512'(mrdata[1]));
    endtask

    task automatic cyc(input bit we, input bit re, input logic [7:0] a,
                       input logic [31:0] wd, input logic [NEVT-1:0] ev);
        @(negedge clk);
        reg_wen = we; reg_ren = re; reg_addr = a; reg_wdata = wd; evt = ev;
        model_step(we, re, a, wd, ev);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d, '0);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b0, 1'b1, a, 32'd0, '0);
    endtask

    task automatic ev_cyc(input logic [NEVT-1:0] ev);
        cyc(1'b0, 1'b0, 8'h00, 32'd0, ev);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cnt_a"}, cnt_out_a, '0);
        check({tag, "_cnt_b"}, 512'(cnt_out_b), '0);
        check({tag, "_irq"}, 512'({irq_a, irq_b}), '0);
        check({tag, "_rvalid"}, 512'({rvalid_a, rvalid_b}), '0);
        check({tag, "_rdata"}, 512'({rdata_a, rdata_b}), '0);
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h7F;
            default: return 8'(16 + $urandom_range(0, 33));
        endcase
    endfunction

    initial begin
        logic [7:0]      a;
        logic [31:0]     wd;
        bit              we, re;
        logic [NEVT-1:0] ev;

        rst = 1'b0; evt = '0; reg_wen = 0; reg_ren = 0; reg_addr = '0; reg_wdata = '0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // basic count
        wr(8'h11, 32'h8000_0003);
        wr(8'h00, 32'h1);
        for (int k = 0; k < 5; k++) ev_cyc(NEVT'(1) << 3);
        check("basic_cnt0", 512'(cnt_out_a[31:0]), 512'd5);
        rd(8'h10);
        check("basic_rd", 512'(rdata_a), 512'd5);

        // wrap and interrupt
        wr(8'h14, 32'hFFFF_FFFE);
        wr(8'h02, 32'h4);
        wr(8'h15, 32'h8000_0000);
        ev_cyc(NEVT'(1));
        ev_cyc(NEVT'(1));
        check("wrap_cnt2", 512'(cnt_out_a[95:64]), 512'd0);
        check("wrap_irq", 512'({irq_a, irq_b}), 512'(2'b11));
        wr(8'h01, 32'h4);
        check("w1c_irq", 512'(irq_a), 512'd0);

        // freeze and write priority
        wr(8'h13, 32'h8000_0001);
        wr(8'h00, 32'h5);
        for (int k = 0; k < 3; k++) ev_cyc('1);
        check("frz_hold", 512'(cnt_out_a[31:0]), 512'd5);
        wr(8'h00, 32'h1);
        cyc(1'b1, 1'b0, 8'h12, 32'h55, NEVT'(2));
        check("wr_over_inc", 512'(cnt_out_a[63:32]), 512'h55);
        cyc(1'b1, 1'b0, 8'h00, 32'h3, '1);
        check("clear_all", cnt_out_a, '0);
        rd(8'h00);
        check("ctrl_rd", 512'(rdata_a), 512'd1);

        // boundaries
        wr(8'h17, 32'h8000_001F);
        for (int k = 0; k < 3; k++) ev_cyc('1);
        check("sel_oob", 512'(cnt_out_a[127:96]), 512'd0);
        rd(8'h7F);
        check("unmapped_rd", 512'(rdata_a), 512'd0);
        wr(8'h01, 32'hFFFF);
        wr(8'h14, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 8'h01, 32'h4, NEVT'(1));
        rd(8'h01);
        check("ovf_w1c_race", 512'(rdata_a & 32'h4), 512'h4);

        // narrow instance
        wr(8'h16, 32'hFF);
        wr(8'h17, 32'h8000_0002);
        ev_cyc(NEVT'(1) << 2);
        check("b_wrap", 512'(cnt_out_b[31:24]), 512'd0);
        rd(8'h01);
        check("b_ovf3", 512'(rdata_b[3]), 512'd1);
        rd(8'h16);
        check("b_rd_cnt3", 512'(rdata_b), 512'd0);
        wr(8'h18, 32'h77);
        rd(8'h18);
        check("b_unmapped", 512'(rdata_b), 512'd0);

        // reset mid-count
        ev_cyc('1);
        #2;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge clk);
        reg_wen = 0; reg_ren = 0; evt = '0;
        rst = 1'b1;
        wr(8'h11, 32'h8000_0003);
        for (int k = 0; k < 3; k++) ev_cyc('1);
        check("post_rst_idle", cnt_out_a, '0);
        cyc(1'b1, 1'b0, 8'h00, 32'h1, '1);
        check("en_same_cycle", cnt_out_a, '0);
        ev_cyc('1);
        check("post_rst_count", 512'(cnt_out_a[31:0]), 512'd1);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            we = ($urandom_range(0, 99) < 35);
            re = ($urandom_range(0, 2) == 0);
            a  = pick_addr();
            wd = $urandom;
            ev = NEVT'($urandom);
            if (a == 8'h00)
                wd = {29'd0, $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                      $urandom_range(0, 9) != 0};
            else if (a >= 8'h10 && !a[0] && $urandom_range(0, 1) == 1)
                wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else if (a >= 8'h10 && a[0])
                wd = {$urandom_range(0, 4) != 0, 26'd0, 5'($urandom_range(0, 31))};
            cyc(we, re, a, wd, ev);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
